// File: rtl/counter_pkg.sv
// Shared constants and helpers for the cascaded modulo counter.
package counter_pkg;

   localparam int unsigned DIG_W_DEF = 4;
   localparam int unsigned MOD_DEC   = 10;
   localparam int unsigned MOD_SEX   = 6;

   // Ceil-log2 with a floor of 1 bit, so a counter of modulus 1 still has a register.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-MOD digit stage: clear > load > step, with combinational wrap to the next stage.
module mod_digit
   import counter_pkg::*;
#(
   parameter int unsigned DIG_W = DIG_W_DEF,
   parameter int unsigned MOD   = MOD_DEC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             ld,
   input  logic [DIG_W-1:0] ld_val,
   input  logic             step,
   input  logic             up_dn,
   output logic [DIG_W-1:0] q,
   output logic             wrap
);

   localparam logic [DIG_W-1:0] MAXV = DIG_W'(MOD - 1);

   logic [DIG_W-1:0] q_d, q_q;
   logic             at_max, at_zero;

   assign at_max  = (q_q == MAXV);
   assign at_zero = (q_q == '0);

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (ld) begin
         q_d = ld_val;
      end else if (step) begin
         if (up_dn) q_d = at_max  ? '0   : q_q + DIG_W'(1);
         else       q_d = at_zero ? MAXV : q_q - DIG_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q    = q_q;
   assign wrap = step & (up_dn ? at_max : at_zero);

endmodule

// File: rtl/mod_counter_chain.sv
// Cascaded modulo counter with prescaler, up/down, sync clear and range-checked parallel load.
module mod_counter_chain
   import counter_pkg::*;
#(
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned DIG_W    = DIG_W_DEF,
   parameter int unsigned MOD_LO   = MOD_DEC,
   parameter int unsigned MOD_TOP  = MOD_SEX,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic                    load,
   input  logic [DIGITS*DIG_W-1:0] load_val,
   input  logic                    up_dn,
   output logic [DIGITS*DIG_W-1:0] cnt,
   output logic                    carry_out
);

   localparam int unsigned PS_W = clog2_min1(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps_d, ps_q;
   logic            ps_last;
   logic            carry_d, carry_q;
   logic [DIGITS:0] stp;

   assign ps_last = (ps_q == PS_LAST);
   assign stp[0]  = en & ps_last;

   always_comb begin
      ps_d = ps_q;
      if (clr || load) ps_d = '0;
      else if (en)     ps_d = ps_last ? '0 : ps_q + PS_W'(1);
   end

   // Carry from the top stage is a full-chain wrap; clr/load discard the step.
   always_comb begin
      carry_d = stp[DIGITS] & ~clr & ~load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q    <= '0;
         carry_q <= 1'b0;
      end else begin
         ps_q    <= ps_d;
         carry_q <= carry_d;
      end
   end

   assign carry_out = carry_q;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      localparam int unsigned MOD_I = (i == DIGITS - 1) ? MOD_TOP : MOD_LO;

      logic [DIG_W-1:0] raw, ld_ok;

      assign raw   = load_val[i*DIG_W +: DIG_W];
      assign ld_ok = (32'(raw) < MOD_I) ? raw : '0;

      mod_digit #(
         .DIG_W (DIG_W),
         .MOD   (MOD_I)
      ) u_digit (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (clr),
         .ld     (load),
         .ld_val (ld_ok),
         .step   (stp[i]),
         .up_dn  (up_dn),
         .q      (cnt[i*DIG_W +: DIG_W]),
         .wrap   (stp[i+1])
      );
   end

endmodule
